// File: rtl/process_gyro_multi.sv
// Multi-axis gyro rate integrator with averaged bias calibration.
// Angles saturate or wrap per channel; sat_flag is sticky until cleared.
module process_gyro_multi #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CAL_LOG2  = 4
) (
    input  logic                          clk_100mhz,
    input  logic                          rst_in,
    input  logic                          sample_valid,
    input  logic [CHANNELS*IN_WIDTH-1:0]  gyro_in,
    input  logic                          cal_start,
    input  logic                          zero_in,
    input  logic [CHANNELS-1:0]           wrap_en,
    output logic [CHANNELS*ACC_WIDTH-1:0] angle_out,
    output logic [CHANNELS*IN_WIDTH-1:0]  bias_out,
    output logic                          out_valid,
    output logic                          cal_busy,
    output logic [CHANNELS-1:0]           sat_flag
);

    localparam int DW = IN_WIDTH + 1;
    localparam int SW = IN_WIDTH + CAL_LOG2;
    localparam int CW = CAL_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << CAL_LOG2) - 1);
    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_CAL = 1'b1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] angle_q [CHANNELS];
    logic [ACC_WIDTH-1:0] angle_d [CHANNELS];
    logic [IN_WIDTH-1:0]  bias_q  [CHANNELS];
    logic [IN_WIDTH-1:0]  bias_d  [CHANNELS];
    logic [SW-1:0]        sum_q   [CHANNELS];
    logic [SW-1:0]        sum_d   [CHANNELS];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHANNELS-1:0]  sat_q, sat_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cal_busy_q;

    logic [IN_WIDTH-1:0]  gyro_w  [CHANNELS];
    logic [DW-1:0]        delta_w [CHANNELS];
    logic [ACC_WIDTH:0]   next_w  [CHANNELS];
    logic [SW-1:0]        acc_w   [CHANNELS];
    logic [IN_WIDTH-1:0]  bias_w  [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign gyro_w[k]  = gyro_in[k*IN_WIDTH +: IN_WIDTH];
        assign delta_w[k] = DW'(signed'(gyro_w[k])) - DW'(signed'(bias_q[k]));
        // One spare bit so overflow shows up as a sign mismatch.
        assign next_w[k]  = (ACC_WIDTH+1)'(signed'(delta_w[k]))
                          + (ACC_WIDTH+1)'(signed'(angle_q[k]));
        assign acc_w[k]   = sum_q[k] + SW'(signed'(gyro_w[k]));
        assign bias_w[k]  = IN_WIDTH'(signed'(acc_w[k]) >>> CAL_LOG2);
        assign angle_out[k*ACC_WIDTH +: ACC_WIDTH] = angle_q[k];
        assign bias_out[k*IN_WIDTH +: IN_WIDTH]    = bias_q[k];
    end

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        bias_d      = bias_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (cal_start) begin
                    state_d = S_CAL;
                    cnt_d   = '0;
                    for (int k = 0; k < CHANNELS; k++) sum_d[k] = '0;
                end else if (sample_valid && !zero_in) begin
                    out_valid_d = 1'b1;
                    for (int k = 0; k < CHANNELS; k++) begin
                        if ((next_w[k][ACC_WIDTH] != next_w[k][ACC_WIDTH-1])
                            && !wrap_en[k]) begin
                            angle_d[k] = next_w[k][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                            sat_d[k]   = 1'b1;
                        end else begin
                            angle_d[k] = next_w[k][ACC_WIDTH-1:0];
                        end
                    end
                end
            end
            S_CAL: begin
                if (sample_valid) begin
                    sum_d = acc_w;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        bias_d  = bias_w;
                        sat_d   = '0;
                        for (int k = 0; k < CHANNELS; k++) angle_d[k] = '0;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
        if (zero_in) begin
            out_valid_d = 1'b0;
            sat_d       = '0;
            for (int k = 0; k < CHANNELS; k++) angle_d[k] = '0;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_in) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            cal_busy_q  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                angle_q[k] <= '0;
                bias_q[k]  <= '0;
                sum_q[k]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            bias_q      <= bias_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            cal_busy_q  <= (state_d == S_CAL);
        end
    end

    assign out_valid = out_valid_q;
    assign cal_busy  = cal_busy_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_process_gyro_multi.sv
// Scoreboard bench for process_gyro_multi: a 32-bit default instance
// plus an 18-bit instance used for the saturate/wrap scenario.
module tb_process_gyro_multi;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        sample_valid;
    logic [47:0] gyro_in;
    logic        cal_start;
    logic        zero_in;
    logic [95:0] angle_out;
    logic [47:0] bias_out;
    logic        out_valid;
    logic        cal_busy;
    logic [2:0]  sat_flag;

    logic        sv2;
    logic [53:0] angle2;
    logic [47:0] bias2;
    logic        ov2;
    logic        busy2;
    logic [2:0]  sat2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] exp_q[$];
    longint      m_ang [3];
    longint      m_bias[3];

    always #5 clk = ~clk;

    process_gyro_multi dut (
        .clk_100mhz  (clk),
        .rst_in      (rst_in),
        .sample_valid(sample_valid),
        .gyro_in     (gyro_in),
        .cal_start   (cal_start),
        .zero_in     (zero_in),
        .wrap_en     (3'b000),
        .angle_out   (angle_out),
        .bias_out    (bias_out),
        .out_valid   (out_valid),
        .cal_busy    (cal_busy),
        .sat_flag    (sat_flag)
    );

    process_gyro_multi #(.ACC_WIDTH(18)) dut18 (
        .clk_100mhz  (clk),
        .rst_in      (rst_in),
        .sample_valid(sv2),
        .gyro_in     (gyro_in),
        .cal_start   (1'b0),
        .zero_in     (1'b0),
        .wrap_en     (3'b100),
        .angle_out   (angle2),
        .bias_out    (bias2),
        .out_valid   (ov2),
        .cal_busy    (busy2),
        .sat_flag    (sat2)
    );

    task automatic set_gyro(input int g0, input int g1, input int g2);
        gyro_in[15:0]  = g0[15:0];
        gyro_in[31:16] = g1[15:0];
        gyro_in[47:32] = g2[15:0];
    endtask

    function automatic logic [95:0] model_vec();
        logic [95:0] v;
        for (int k = 0; k < 3; k++) v[k*32 +: 32] = m_ang[k][31:0];
        return v;
    endfunction

    function automatic logic [47:0] bias_vec();
        logic [47:0] v;
        for (int k = 0; k < 3; k++) v[k*16 +: 16] = m_bias[k][15:0];
        return v;
    endfunction

    // Drive one RUN-state sample, push its expected angles, then check
    // the pulse and pop the scoreboard one cycle later.
    task automatic drive_sample(input int g0, input int g1, input int g2);
        int g[3];
        logic [95:0] e;
        g[0] = g0; g[1] = g1; g[2] = g2;
        set_gyro(g0, g1, g2);
        sample_valid = 1'b1;
        for (int k = 0; k < 3; k++) m_ang[k] = m_ang[k] + g[k] - m_bias[k];
        exp_q.push_back(model_vec());
        @(posedge clk); #1;
        sample_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sample_pulse: out_valid=%b want 1", out_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: nothing expected");
        end else begin
            e = exp_q.pop_front();
            if (angle_out !== e) begin
                n_fail++;
                $display("FAIL angle: got %h want %h", angle_out, e);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_pulse: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_in       = 1'b0;
        sample_valid = 1'b1;
        sv2          = 1'b1;
        set_gyro(1000, 2000, 3000);
        repeat (2) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sv2          = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_ang[k]  = 0;
            m_bias[k] = 0;
        end
        n_checks++;
        if ({angle_out, bias_out, out_valid, cal_busy, sat_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ang=%h bias=%h ov=%b busy=%b sat=%b want 0",
                     angle_out, bias_out, out_valid, cal_busy, sat_flag);
        end
        n_checks++;
        if ({angle2, bias2, ov2, busy2, sat2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs18: ang=%h sat=%b want 0", angle2, sat2);
        end
        rst_in = 1'b1;
        set_gyro(0, 0, 0);
    endtask

    task automatic test_integrate();
        for (int i = 0; i < 10; i++) begin
            drive_sample(256, 512, -2560);
            if (i < 5) idle_cycle();
        end
        n_checks++;
        if (angle_out !== {32'hFFFF_9C00, 32'd5120, 32'd2560}) begin
            n_fail++;
            $display("FAIL integrate_final: got %h want (2560,5120,-25600)", angle_out);
        end
    endtask

    task automatic test_calibrate();
        // Sample alongside cal_start must not be counted.
        cal_start    = 1'b1;
        sample_valid = 1'b1;
        set_gyro(100, 100, 100);
        @(posedge clk); #1;
        cal_start    = 1'b0;
        sample_valid = 1'b0;
        n_checks++;
        if (cal_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cal_enter: cal_busy=%b want 1", cal_busy);
        end
        set_gyro(5, -3, 7);
        for (int i = 0; i < 16; i++) begin
            sample_valid = 1'b1;
            cal_start    = (i == 3);
            @(posedge clk); #1;
            sample_valid = 1'b0;
            cal_start    = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || cal_busy !== (i < 15)) begin
                n_fail++;
                $display("FAIL cal_step%0d: ov=%b busy=%b want 0/%b",
                         i, out_valid, cal_busy, (i < 15));
            end
        end
        m_bias[0] = 5; m_bias[1] = -3; m_bias[2] = 7;
        for (int k = 0; k < 3; k++) m_ang[k] = 0;
        n_checks++;
        if (bias_out !== bias_vec()) begin
            n_fail++;
            $display("FAIL cal_bias: got %h want %h", bias_out, bias_vec());
        end
        n_checks++;
        if (angle_out !== '0 || sat_flag !== 3'b000) begin
            n_fail++;
            $display("FAIL cal_clear: ang=%h sat=%b want 0", angle_out, sat_flag);
        end
        drive_sample(6, -3, 7);
        n_checks++;
        if (angle_out !== {32'd0, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL cal_after: got %h want (1,0,0)", angle_out);
        end
    endtask

    task automatic test_zero();
        drive_sample(100, 200, 300);
        zero_in      = 1'b1;
        sample_valid = 1'b1;
        set_gyro(50, 50, 50);
        @(posedge clk); #1;
        zero_in      = 1'b0;
        sample_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_ang[k] = 0;
        n_checks++;
        if (angle_out !== '0 || out_valid !== 1'b0 || sat_flag !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_priority: ang=%h ov=%b sat=%b want 0",
                     angle_out, out_valid, sat_flag);
        end
        n_checks++;
        if (bias_out !== bias_vec()) begin
            n_fail++;
            $display("FAIL zero_bias_kept: got %h want %h", bias_out, bias_vec());
        end
    endtask

    task automatic test_reset_mid_cal();
        cal_start = 1'b1;
        @(posedge clk); #1;
        cal_start = 1'b0;
        set_gyro(9, 9, 9);
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        rst_in       = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_ang[k]  = 0;
            m_bias[k] = 0;
        end
        n_checks++;
        if (bias_out !== '0 || cal_busy !== 1'b0 || angle_out !== '0) begin
            n_fail++;
            $display("FAIL midcal_reset: bias=%h busy=%b ang=%h want 0",
                     bias_out, cal_busy, angle_out);
        end
        drive_sample(10, 20, 30);
    endtask

    task automatic test_saturate_wrap();
        int          w;
        logic [53:0] e;
        rst_in = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b1;
        set_gyro(32767, 32767, 32767);
        for (int i = 0; i < 5; i++) begin
            sv2 = 1'b1;
            @(posedge clk); #1;
            sv2 = 1'b0;
            n_checks++;
            if (ov2 !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_pulse%0d: ov=%b want 1", i, ov2);
            end
        end
        w = 131071;
        e[17:0]  = w[17:0];
        e[35:18] = w[17:0];
        w = -98309;
        e[53:36] = w[17:0];
        n_checks++;
        if (angle2 !== e) begin
            n_fail++;
            $display("FAIL sat_angles: got %h want %h", angle2, e);
        end
        n_checks++;
        if (sat2 !== 3'b011) begin
            n_fail++;
            $display("FAIL sat_flags: got %b want 011", sat2);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        sample_valid = 1'b0;
        sv2          = 1'b0;
        cal_start    = 1'b0;
        zero_in      = 1'b0;
        gyro_in      = '0;
        @(posedge clk); #1;
        test_reset();
        test_integrate();
        test_calibrate();
        test_zero();
        test_reset_mid_cal();
        test_saturate_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/process_gyro_multi.md
PROCESS_GYRO_MULTI -- requirements
Module: process_gyro_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of gyro axes.
REQ-002 SHALL have parameter IN_WIDTH, default 16, signed rate sample width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, signed angle accumulator width; ACC_WIDTH > IN_WIDTH+1.
REQ-004 SHALL have parameter CAL_LOG2, default 4; calibration averages 2^CAL_LOG2 samples.
REQ-005 SHALL have port clk_100mhz  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_in  input  1  synchronous active-low reset.
REQ-007 SHALL have port sample_valid  input  1  gyro_in holds a new sample this cycle.
REQ-008 SHALL have port gyro_in  input  CHANNELS*IN_WIDTH  signed rates, channel k at bits [k*IN_WIDTH +: IN_WIDTH].
REQ-009 SHALL have port cal_start  input  1  single-cycle request to measure bias.
REQ-010 SHALL have port zero_in  input  1  clear all angles and sticky flags.
REQ-011 SHALL have port wrap_en  input  CHANNELS  per channel: 1 = two's-complement wrap, 0 = saturate.
REQ-012 SHALL have port angle_out  output  CHANNELS*ACC_WIDTH  signed integrated angles, same packing as gyro_in.
REQ-013 SHALL have port bias_out  output  CHANNELS*IN_WIDTH  current signed bias per channel.
REQ-014 SHALL have port out_valid  output  1  one-cycle pulse: angle_out just updated.
REQ-015 SHALL have port cal_busy  output  1  high while in CAL state.
REQ-016 SHALL have port sat_flag  output  CHANNELS  sticky: channel clamped since last clear.

Function
REQ-017 SHALL implement FSM with states RUN and CAL; reset state RUN.
REQ-018 In RUN, on sample_valid, SHALL compute per channel delta = gyro - bias at IN_WIDTH+1 bits, sign-extend to ACC_WIDTH, add to angle.
REQ-019 Angle update and out_valid pulse SHALL appear the cycle after sample_valid (latency 1); out_valid low otherwise.
REQ-020 On overflow with wrap_en[k]=0, angle k SHALL clamp to max/min signed ACC_WIDTH value and set sat_flag[k]; with wrap_en[k]=1 SHALL wrap modulo 2^ACC_WIDTH, sat_flag[k] unchanged.
REQ-021 In RUN, cal_start SHALL move to CAL next cycle, clear bias sums and sample counter; a sample_valid in that same cycle SHALL be neither integrated nor counted.
REQ-022 In CAL, each sample_valid SHALL add gyro_in to per-channel sum of IN_WIDTH+CAL_LOG2 bits and increment counter; angles held, out_valid low.
REQ-023 On the 2^CAL_LOG2-th CAL sample, next cycle SHALL load bias = sum arithmetically shifted right by CAL_LOG2, clear all angles and sat_flag, return to RUN, drop cal_busy.
REQ-024 cal_start while in CAL SHALL be ignored.
REQ-025 zero_in SHALL clear angles and sat_flag next cycle in either state, taking priority over a simultaneous sample_valid (no integration, no out_valid); bias and calibration progress unaffected.
REQ-026 cal_busy SHALL equal (state == CAL), registered.

Reset
REQ-027 rst_in low at a clock edge SHALL force: state RUN, angles 0, bias 0, sums and counter 0, out_valid 0, cal_busy 0, sat_flag 0; overrides all other inputs including mid-calibration.

Verification
REQ-028 Reset: hold rst_in low 2 cycles -> all outputs 0, cal_busy 0.
REQ-029 Integrate: defaults, gyro=(256,512,-2560), 10 valid samples -> angles (2560,5120,-25600), 10 out_valid pulses each 1 cycle after its sample.
REQ-030 Calibrate: cal_start, 16 samples of (5,-3,7) -> bias_out (5,-3,7), angles 0, cal_busy low 1 cycle after 16th; then one sample (6,-3,7) -> angles (1,0,0).
REQ-031 Saturate/wrap: ACC_WIDTH=18, wrap_en=3'b100, 5 samples of 32767 on all channels -> ch0,ch1 = 131071 with sat_flag=3'b011; ch2 = -98309.
REQ-032 zero_in together with sample_valid after angles nonzero -> angles 0 next cycle, out_valid 0, sat_flag 0.
REQ-033 Reset mid-calibration: cal_start, 8 samples, rst_in low -> bias 0, cal_busy 0, RUN; subsequent sample integrates unbiased.
